seq_alu_resp: RTL and testbench
===============================

Name: seq_alu_resp

Overview:
- Synthesizable responder for the op_start/operation/operand_a/operand_b/result protocol that the block-level benches drive.
- Accepts one operation per handshake. ADD, OR and AND complete in one cycle. MUL runs as a multi-cycle shift-add.
- Signals completion with an op_done pulse and flow-controls the initiator with busy.
- Sits behind the operation interface as the execution unit that the bench initiator talks to.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_start  input  1  request strobe; sampled on rising edge
- operation  input  operation_t (2)  0=ADD, 1=MUL, 2=OR, 3=AND
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand
- busy  output  1  high while a MUL is in progress; requests are not accepted
- op_done  output  1  one-cycle pulse; result valid
- result  output  2*WIDTH  registered result; holds until the next completion

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, op_done=0, result=0, state=IDLE, iteration counter=0, partial product=0.
  - Takes effect immediately, including mid-MUL. The aborted operation never produces op_done.
- Accept: a request is accepted at rising edge E0 when op_start=1 and busy=0. Operands and operation are captured at E0.
- op_start while busy=1: ignored, with no side effects and no queuing.
- ADD/OR/AND:
  - After E0: result is valid and op_done=1 for exactly one cycle; busy stays 0.
  - ADD: result = zero-extended WIDTH+1 bit sum, so the carry lands in bit WIDTH.
  - OR/AND: result = zero-extended WIDTH-bit result, upper bits 0.
- MUL:
  - After E0: state=MUL_RUN, busy=1.
  - Radix-2 shift-add, one multiplier bit per cycle, over edges E1..E_WIDTH.
  - After E_WIDTH: result = full 2*WIDTH-bit unsigned product, op_done=1 for one cycle, busy=0, state=IDLE.
  - Latency from accept to op_done is WIDTH cycles (8 at default).
- result is updated only on completion. It is not disturbed while MUL_RUN accumulates; internal partial-product registers are used.
- Back-to-back:
  - In the op_done cycle busy=0, so a new op_start is accepted at that same edge.
  - Single-cycle ops can therefore be issued every cycle, and op_done stays high on consecutive cycles.
- States: IDLE -> (accept, op=MUL) -> MUL_RUN -> (counter==WIDTH-1) -> IDLE. All other accepted ops stay in IDLE.
- Illegal operation encodings: none exist with a 2-bit enum. A default branch yields result=0 with op_done.
- Operand changes after E0 have no effect on the operation in flight.

Decomposition:
- typedef_pkg holds:
  - operation_t (existing)
  - localparam OP_COUNT=4
  - state enum alu_state_t {IDLE, MUL_RUN}
- Sub-module shift_add_mul (start, a, b -> done, product, parameter WIDTH) contains the counter and accumulator.
- seq_alu_resp owns the handshake, the single-cycle datapath and the result mux.

Test Plan:
1. ADD a=255, b=255 -> op_done one cycle after accept, result=510 (0x01FE), busy never high.
2. MUL a=255, b=255 -> busy high 8 cycles; op_done on 8th cycle after accept; result=65025 (0xFE01). Also MUL 0*200 -> result=0.
3. OR a=0xA5, b=0x5A -> result=0x00FF; AND a=0xA5, b=0x0F -> result=0x0005; upper byte 0.
4. Start MUL 12*13, pulse op_start with ADD 1+1 at cycle 3 -> ADD ignored; result=156, single op_done.
5. Start MUL 200*3, assert rst_n=0 at cycle 4 -> busy/op_done/result=0 immediately. After release, AND 0xFF&0x3C -> result=0x003C.
6. Back-to-back ADD 1+2, OR 4|8, AND 7&6 on consecutive edges -> op_done high 3 consecutive cycles, result sequence 3, 12, 6. Follow with MUL 16*16 accepted on the last op_done edge -> result=256.

Source files
------------

// File: rtl/typedef_pkg.sv
// Shared types for the sequential ALU responder: operation encoding and control states.
// No logic here; latency and backpressure are defined by the modules that import it.
// The operation enum covers all four 2-bit codes, so no illegal encoding can be presented.
package typedef_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_OR  = 2'd2,
        OP_AND = 2'd3
    } operation_t;

    localparam int OP_COUNT = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Radix-2 unsigned shift-add multiplier, one multiplier bit per clock.
// Latency: done is asserted combinationally during the WIDTH-th cycle after start.
// No backpressure; the caller must not pulse start while a multiply is running.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 run_q,    run_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;

        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (run_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // The final partial sum is handed out combinationally so the caller can register it on the done edge.
    assign done    = run_q && (cnt_q == LAST);
    assign product = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/seq_alu_resp.sv
// Execution unit behind the op_start/operation handshake: ADD/OR/AND, plus a shift-add MUL.
// Latency: single-cycle ops finish on the accept edge; MUL finishes WIDTH edges after accept.
// Backpressure: busy is high during a MUL and op_start is then ignored without queuing.
module seq_alu_resp
    import typedef_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_start,
    input  operation_t           operation,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    alu_state_t           state_q,   state_d;
    logic                 busy_q,    busy_d;
    logic                 op_done_q, op_done_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH:0]       sum;

    assign accept = op_start && !busy_q;
    assign sum    = {1'b0, operand_a} + {1'b0, operand_b};

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (operand_a),
        .b       (operand_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        op_done_d = 1'b0;
        result_d  = result_q;
        mul_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_done_d = 1'b1;
                    case (operation)
                        OP_ADD:  result_d = {{(WIDTH-1){1'b0}}, sum};
                        OP_OR:   result_d = {{WIDTH{1'b0}}, operand_a | operand_b};
                        OP_AND:  result_d = {{WIDTH{1'b0}}, operand_a & operand_b};
                        OP_MUL: begin
                            // result keeps its old value while the multiplier accumulates
                            op_done_d = 1'b0;
                            mul_start = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = MUL_RUN;
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            MUL_RUN: begin
                if (mul_done) begin
                    result_d  = mul_product;
                    op_done_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            op_done_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            op_done_q <= op_done_d;
            result_q  <= result_d;
        end
    end

    assign busy    = busy_q;
    assign op_done = op_done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_seq_alu_resp.sv
// Directed bench for seq_alu_resp: vector table for single operations plus hand-written
// sequences for ignored requests, mid-MUL reset and back-to-back issue.
module tb_seq_alu_resp;
    import typedef_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_start;
    operation_t  operation;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic        busy;
    logic        op_done;
    logic [15:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    seq_alu_resp #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_start  (op_start),
        .operation (operation),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .op_done   (op_done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        operation_t  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_res;
        int          exp_edge;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request and waits (bounded) for op_done; edge_n counts rising edges after the accept edge.
    task automatic do_op(input operation_t op, input logic [7:0] xa, input logic [7:0] xb,
                         output logic [15:0] res, output int edge_n, output int busy_n,
                         output logic busy_at_done, output logic done_after);
        @(negedge clk);
        operation = op; operand_a = xa; operand_b = xb; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0; operand_a = ~xa; operand_b = ~xb;
        edge_n = 0; busy_n = 0;
        while (op_done !== 1'b1 && edge_n < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            edge_n++;
        end
        res = result;
        busy_at_done = busy;
        @(negedge clk);
        done_after = op_done;
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] prev;
        int          edge_n, busy_n, ndone, fdone;
        logic        busy_at_done, done_after;

        vecs[0] = '{OP_ADD, 8'd255, 8'd255, 16'h01FE, 0, 0};
        vecs[1] = '{OP_MUL, 8'd255, 8'd255, 16'hFE01, 8, 8};
        vecs[2] = '{OP_MUL, 8'd0,   8'd200, 16'h0000, 8, 8};
        vecs[3] = '{OP_OR,  8'hA5,  8'h5A,  16'h00FF, 0, 0};
        vecs[4] = '{OP_AND, 8'hA5,  8'h0F,  16'h0005, 0, 0};
        vecs[5] = '{OP_ADD, 8'h80,  8'h80,  16'h0100, 0, 0};
        vecs[6] = '{OP_MUL, 8'd1,   8'd1,   16'h0001, 8, 8};
        vecs[7] = '{OP_MUL, 8'd128, 8'd255, 16'h7F80, 8, 8};
        vecs[8] = '{OP_MUL, 8'hAB,  8'hCD,  16'h88EF, 8, 8};

        rst_n = 1'b0; op_start = 1'b0; operation = OP_ADD; operand_a = '0; operand_b = '0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, op_done}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, edge_n, busy_n, busy_at_done, done_after);
            chk($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp_res});
            chk($sformatf("vec%0d_latency", i), edge_n, vecs[i].exp_edge);
            chk($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].exp_busy);
            chk($sformatf("vec%0d_busy_at_done", i), {31'd0, busy_at_done}, 32'd0);
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, done_after}, 32'd0);
        end

        // MUL 12*13 with an ADD request landing while busy
        @(negedge clk);
        prev = result;
        operation = OP_MUL; operand_a = 8'd12; operand_b = 8'd13; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        ndone = 0; fdone = -1;
        for (int k = 0; k < 14; k++) begin
            if (op_done === 1'b1) begin
                ndone++;
                if (fdone < 0) fdone = k;
                res = result;
            end
            if (k == 3) begin
                operation = OP_ADD; operand_a = 8'd1; operand_b = 8'd1; op_start = 1'b1;
            end
            if (k == 4) begin
                op_start = 1'b0;
                chk("ignored_add_result_hold", {16'd0, result}, {16'd0, prev});
                chk("ignored_add_busy", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
        end
        chk("mul_busy_done_count", ndone, 1);
        chk("mul_busy_latency", fdone, 8);
        chk("mul_busy_result", {16'd0, res}, 32'd156);

        // reset in the middle of MUL 200*3
        operation = OP_MUL; operand_a = 8'd200; operand_b = 8'd3; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, op_done}, 32'd0);
        chk("midreset_result", {16'd0, result}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (op_done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("aborted_no_done", ndone, 0);
        do_op(OP_AND, 8'hFF, 8'h3C, res, edge_n, busy_n, busy_at_done, done_after);
        chk("post_reset_and", {16'd0, res}, 32'h3C);
        chk("post_reset_and_latency", edge_n, 0);

        // back-to-back single-cycle ops, then MUL accepted in the last op_done cycle
        @(negedge clk);
        operation = OP_ADD; operand_a = 8'd1; operand_b = 8'd2; op_start = 1'b1;
        @(negedge clk);
        chk("b2b_add_done", {31'd0, op_done}, 32'd1);
        chk("b2b_add_result", {16'd0, result}, 32'd3);
        operation = OP_OR; operand_a = 8'd4; operand_b = 8'd8;
        @(negedge clk);
        chk("b2b_or_done", {31'd0, op_done}, 32'd1);
        chk("b2b_or_result", {16'd0, result}, 32'd12);
        operation = OP_AND; operand_a = 8'd7; operand_b = 8'd6;
        @(negedge clk);
        chk("b2b_and_done", {31'd0, op_done}, 32'd1);
        chk("b2b_and_result", {16'd0, result}, 32'd6);
        chk("b2b_and_busy", {31'd0, busy}, 32'd0);
        operation = OP_MUL; operand_a = 8'd16; operand_b = 8'd16;
        @(negedge clk);
        op_start = 1'b0;
        chk("b2b_mul_accepted", {31'd0, busy}, 32'd1);
        chk("b2b_mul_no_done", {31'd0, op_done}, 32'd0);
        edge_n = 0;
        while (op_done !== 1'b1 && edge_n < 40) begin
            @(negedge clk);
            edge_n++;
        end
        chk("b2b_mul_latency", edge_n, 8);
        chk("b2b_mul_result", {16'd0, result}, 32'd256);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
